// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision round/pack datapath.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3
    } round_mode_e;

    localparam logic [7:0] EXP_MAX  = 8'd255;
    localparam logic [7:0] EXP_MAXF = 8'd254;
    localparam int         FRAC_W   = 23;

    // Bit positions inside the {overflow, underflow, inexact} flag vector
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_NX  = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  flags;
    } pack_t;

endpackage

// File: rtl/fpu_round_incr.sv
// Round-increment decision from sign, mantissa lsb, guard and sticky bits.
module fpu_round_incr
    import fpu_pkg::*;
(
    input  logic        sign,
    input  logic        lsb,
    input  logic        guard,
    input  logic        sticky,
    input  round_mode_e rm,
    output logic        incr
);

    // Unknown mode codes fall back to round-to-nearest-even
    always_comb begin
        incr = guard & (sticky | lsb);
        case (rm)
            RTZ:     incr = 1'b0;
            RDN:     incr = sign & (guard | sticky);
            RUP:     incr = !sign & (guard | sticky);
            default: incr = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fpu_round_pack.sv
// Two-stage round-and-pack for IEEE-754 single precision with valid/ready flow control.
// Define FPU_ROUND_MODES_EN to add the rm_i port and directed rounding modes; default is RNE only.
module fpu_round_pack
    import fpu_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        sign_i,
    input  logic [7:0]  exp_i,
    input  logic [24:0] mant_i,
    input  logic        sticky_i,
`ifdef FPU_ROUND_MODES_EN
    input  logic [2:0]  rm_i,
`endif
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic [2:0]  flags_o
);

    if (LATENCY != 2) begin : g_latency_check
        $error("fpu_round_pack supports only LATENCY = 2");
    end

    function automatic pack_t pack_result(
        input logic              sign,
        input logic [7:0]        exp,
        input logic [FRAC_W-1:0] frac,
        input logic              zero,
        input logic              ovf,
        input logic              sat,
        input logic              inexact
    );
        pack_t p;
        p.flags          = '0;
        p.flags[FLAG_NX] = inexact;
        if (zero) begin
            p.result          = {sign, 31'd0};
            p.flags[FLAG_UNF] = 1'b1;
        end else if (ovf) begin
            p.flags[FLAG_OVF] = 1'b1;
            p.flags[FLAG_NX]  = 1'b1;
            p.result = sat ? {sign, EXP_MAXF, {FRAC_W{1'b1}}}
                           : {sign, EXP_MAX, {FRAC_W{1'b0}}};
        end else begin
            p.result = {sign, exp, frac};
        end
        return p;
    endfunction

`ifdef FPU_ROUND_MODES_EN
    // Modes that round toward zero for this sign clamp to max finite instead of infinity
    function automatic logic sat_on_ovf(input round_mode_e rm, input logic sign);
        case (rm)
            RTZ:     return 1'b1;
            RDN:     return !sign;
            RUP:     return sign;
            default: return 1'b0;
        endcase
    endfunction
`endif

    logic              vld_p1;
    logic              accept_p2;
    logic              fire_p0;

    round_mode_e       rm_p0;
    logic              incr_p0;
    logic [24:0]       sum_p0;
    logic              zero_p0;
    logic              inexact_p0;

    logic              incr_p1;
    logic [24:0]       sum_p1;
    logic              sign_p1;
    logic [7:0]        exp_p1;
    logic              zero_p1;
    logic              inexact_p1;

    logic              carry_p1;
    logic [8:0]        exp_rnd_p1;
    logic [FRAC_W-1:0] frac_p1;
    logic              ovf_p1;
    logic              sat_p1;
    pack_t             pack_p1;

    assign accept_p2 = !valid_o | ready_i;
    assign ready_o   = !vld_p1 | accept_p2;
    assign fire_p0   = valid_i & ready_o;

`ifdef FPU_ROUND_MODES_EN
    assign rm_p0 = round_mode_e'(rm_i);
`else
    assign rm_p0 = RNE;
`endif

    // ---- stage 0 -> 1: round decision and mantissa increment ----
    fpu_round_incr u_round_incr (
        .sign   (sign_i),
        .lsb    (mant_i[1]),
        .guard  (mant_i[0]),
        .sticky (sticky_i),
        .rm     (rm_p0),
        .incr   (incr_p0)
    );

    always_comb begin
        sum_p0     = {1'b0, mant_i[24:1]} + {24'd0, incr_p0};
        zero_p0    = (exp_i == 8'd0) | !mant_i[24];
        inexact_p0 = zero_p0 ? ((|mant_i) | sticky_i) : (mant_i[0] | sticky_i);
    end

    always_ff @(posedge clk_i) begin
        if (fire_p0) begin
            incr_p1    <= incr_p0;
            sum_p1     <= sum_p0;
            sign_p1    <= sign_i;
            exp_p1     <= exp_i;
            zero_p1    <= zero_p0;
            inexact_p1 <= inexact_p0;
        end
    end

`ifdef FPU_ROUND_MODES_EN
    round_mode_e rm_p1;
    logic        big_p1;

    // Magnitude above max finite even when the chosen mode does not increment
    always_ff @(posedge clk_i) begin
        if (fire_p0) begin
            rm_p1  <= rm_p0;
            big_p1 <= (exp_i == EXP_MAXF) & (&mant_i[24:1]) & (mant_i[0] | sticky_i);
        end
    end
`endif

    // ---- stage 1 -> 2: exponent adjust, special cases, pack ----
    always_comb begin
        carry_p1   = sum_p1[24] & incr_p1;
        exp_rnd_p1 = {1'b0, exp_p1} + {8'd0, carry_p1};
        frac_p1    = carry_p1 ? sum_p1[23:1] : sum_p1[22:0];
`ifdef FPU_ROUND_MODES_EN
        sat_p1 = sat_on_ovf(rm_p1, sign_p1);
        ovf_p1 = (exp_p1 == EXP_MAX) | (exp_rnd_p1 == {1'b0, EXP_MAX}) | (big_p1 & sat_p1);
`else
        sat_p1 = 1'b0;
        ovf_p1 = (exp_p1 == EXP_MAX) | (exp_rnd_p1 == {1'b0, EXP_MAX});
`endif
        pack_p1 = pack_result(sign_p1, exp_rnd_p1[7:0], frac_p1, zero_p1,
                              ovf_p1, sat_p1, inexact_p1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
        end else begin
            if (ready_o) begin
                vld_p1 <= valid_i;
            end
            if (accept_p2) begin
                valid_o <= vld_p1;
                if (vld_p1) begin
                    result_o <= pack_p1.result;
                    flags_o  <= pack_p1.flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Directed-vector bench for fpu_round_pack (default RNE-only build).
module tb_fpu_round_pack;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        sign_i = 1'b0;
    logic [7:0]  exp_i = 8'd0;
    logic [24:0] mant_i = 25'd0;
    logic        sticky_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic [2:0]  flags_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic        st;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    fpu_round_pack #(.LATENCY(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sign_i   (sign_i),
        .exp_i    (exp_i),
        .mant_i   (mant_i),
        .sticky_i (sticky_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .flags_o  (flags_o)
    );

    task automatic set_op(input logic s, input logic [7:0] e, input logic [24:0] m, input logic st);
        sign_i   = s;
        exp_i    = e;
        mant_i   = m;
        sticky_i = st;
        valid_i  = 1'b1;
    endtask

    task automatic single_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                             input logic st, output logic got, output int lat,
                             output logic [31:0] res, output logic [2:0] flg);
        set_op(s, e, m, st);
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        got = valid_o;
        res = result_o;
        flg = flags_o;
    endtask

    task automatic test_reset;
        #2 rst_ni = 1'b0;
        #1;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL reset valid_o: got %b want 0", valid_o); else pass_cnt++;
        total_cnt++; if (result_o !== 32'd0) $display("FAIL reset result_o: got %h want 0", result_o); else pass_cnt++;
        total_cnt++; if (flags_o !== 3'd0) $display("FAIL reset flags_o: got %b want 000", flags_o); else pass_cnt++;
        total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset ready_o: got %b want 1", ready_o); else pass_cnt++;
        repeat (2) @(posedge clk);
        #4 rst_ni = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL post-reset ready/valid: got %b/%b want 1/0", ready_o, valid_o); else pass_cnt++;
    endtask

    task automatic test_exact;
        logic got; int lat; logic [31:0] res; logic [2:0] flg;
        ready_i = 1'b1;
        single_op(1'b0, 8'd127, 25'h1000000, 1'b0, got, lat, res, flg);
        total_cnt++; if (got !== 1'b1 || lat != 2) $display("FAIL exact latency: got valid=%b after %0d edges want 1 after 2", got, lat); else pass_cnt++;
        total_cnt++; if (res !== 32'h3F800000) $display("FAIL exact result: got %h want 3f800000", res); else pass_cnt++;
        total_cnt++; if (flg !== 3'b000) $display("FAIL exact flags: got %b want 000", flg); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL exact retire: valid_o got %b want 0", valid_o); else pass_cnt++;
    endtask

    task automatic test_rounding;
        logic got; int lat; logic [31:0] res; logic [2:0] flg;
        for (int i = 0; i < 5; i++) begin
            single_op(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].st, got, lat, res, flg);
            total_cnt++; if (got !== 1'b1 || res !== vecs[i].r) $display("FAIL round[%0d] result: got %h valid=%b want %h", i, res, got, vecs[i].r); else pass_cnt++;
            total_cnt++; if (flg !== vecs[i].f) $display("FAIL round[%0d] flags: got %b want %b", i, flg, vecs[i].f); else pass_cnt++;
        end
    endtask

    task automatic test_overflow;
        logic got; int lat; logic [31:0] res; logic [2:0] flg;
        for (int i = 5; i < 8; i++) begin
            single_op(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].st, got, lat, res, flg);
            total_cnt++; if (got !== 1'b1 || res !== vecs[i].r) $display("FAIL ovf[%0d] result: got %h valid=%b want %h", i, res, got, vecs[i].r); else pass_cnt++;
            total_cnt++; if (flg !== vecs[i].f) $display("FAIL ovf[%0d] flags: got %b want %b", i, flg, vecs[i].f); else pass_cnt++;
        end
    endtask

    task automatic test_underflow;
        logic got; int lat; logic [31:0] res; logic [2:0] flg;
        for (int i = 8; i < 12; i++) begin
            single_op(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].st, got, lat, res, flg);
            total_cnt++; if (got !== 1'b1 || res !== vecs[i].r) $display("FAIL unf[%0d] result: got %h valid=%b want %h", i, res, got, vecs[i].r); else pass_cnt++;
            total_cnt++; if (flg !== vecs[i].f) $display("FAIL unf[%0d] flags: got %b want %b", i, flg, vecs[i].f); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_r[3];
        exp_r[0] = 32'h41000000;
        exp_r[1] = 32'h41800000;
        exp_r[2] = 32'h42000000;
        ready_i = 1'b1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2 && c <= 4) begin
                total_cnt++; if (valid_o !== 1'b1 || result_o !== exp_r[c-2])
                    $display("FAIL b2b cycle %0d: got valid=%b %h want 1 %h", c, valid_o, result_o, exp_r[c-2]); else pass_cnt++;
            end else begin
                total_cnt++; if (valid_o !== 1'b0) $display("FAIL b2b idle cycle %0d: valid_o got %b want 0", c, valid_o); else pass_cnt++;
            end
            if (c < 3) set_op(1'b0, 8'(130 + c), 25'h1000000, 1'b0);
            else valid_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_r[4];
        int sent, ret, stall;
        logic acc;
        exp_r[0] = 32'h3F800000;
        exp_r[1] = 32'h40000000;
        exp_r[2] = 32'h40800000;
        exp_r[3] = 32'h41000000;
        sent = 0; ret = 0; stall = 0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 30 && ret < 4; c++) begin
            ready_i = !(c >= 2 && c <= 4);
            if (sent < 4) set_op(1'b0, 8'(127 + sent), 25'h1000000, 1'b0);
            else valid_i = 1'b0;
            #1;
            acc = valid_i & ready_o;
            if (!ready_o) stall++;
            if (valid_o && !ready_i) begin
                total_cnt++; if (result_o !== exp_r[ret]) $display("FAIL bp hold cycle %0d: got %h want %h", c, result_o, exp_r[ret]); else pass_cnt++;
            end
            if (valid_o && ready_i) begin
                total_cnt++; if (result_o !== exp_r[ret]) $display("FAIL bp order[%0d]: got %h want %h", ret, result_o, exp_r[ret]); else pass_cnt++;
                ret++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        total_cnt++; if (ret != 4 || sent != 4) $display("FAIL bp count: retired %0d sent %0d want 4/4", ret, sent); else pass_cnt++;
        total_cnt++; if (stall != 3) $display("FAIL bp ready_o low cycles: got %0d want 3", stall); else pass_cnt++;
        stall = 0;
        repeat (4) begin
            #1 if (valid_o) stall++;
            @(posedge clk); #1;
        end
        total_cnt++; if (stall != 0) $display("FAIL bp duplicate: %0d extra valid cycles want 0", stall); else pass_cnt++;
    endtask

    task automatic test_reset_midstream;
        int seen;
        ready_i = 1'b0;
        set_op(1'b0, 8'd254, 25'h1FFFFFF, 1'b0);
        @(posedge clk); #1;
        set_op(1'b1, 8'd0, 25'h0000001, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        total_cnt++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || flags_o !== 3'b101)
            $display("FAIL midrst full: valid/ready/flags got %b/%b/%b want 1/0/101", valid_o, ready_o, flags_o); else pass_cnt++;
        rst_ni = 1'b0;
        #1;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL midrst valid_o: got %b want 0", valid_o); else pass_cnt++;
        total_cnt++; if (result_o !== 32'd0 || flags_o !== 3'd0) $display("FAIL midrst data: got %h/%b want 0/000", result_o, flags_o); else pass_cnt++;
        total_cnt++; if (ready_o !== 1'b1) $display("FAIL midrst ready_o: got %b want 1", ready_o); else pass_cnt++;
        @(posedge clk); #3;
        rst_ni = 1'b1;
        ready_i = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        total_cnt++; if (seen != 0) $display("FAIL midrst stale: %0d valid cycles after release want 0", seen); else pass_cnt++;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'd127, 25'h1FFFFFF, 1'b0, 32'h40000000, 3'b001};
        vecs[1]  = '{1'b0, 8'd127, 25'h1000001, 1'b0, 32'h3F800000, 3'b001};
        vecs[2]  = '{1'b0, 8'd127, 25'h1000003, 1'b0, 32'h3F800002, 3'b001};
        vecs[3]  = '{1'b0, 8'd127, 25'h1000001, 1'b1, 32'h3F800001, 3'b001};
        vecs[4]  = '{1'b1, 8'd128, 25'h1400000, 1'b0, 32'hC0200000, 3'b000};
        vecs[5]  = '{1'b0, 8'd254, 25'h1FFFFFF, 1'b0, 32'h7F800000, 3'b101};
        vecs[6]  = '{1'b1, 8'd255, 25'h1000000, 1'b0, 32'hFF800000, 3'b101};
        vecs[7]  = '{1'b0, 8'd254, 25'h1FFFFFE, 1'b0, 32'h7F7FFFFF, 3'b000};
        vecs[8]  = '{1'b1, 8'd0,   25'h0000001, 1'b0, 32'h80000000, 3'b011};
        vecs[9]  = '{1'b0, 8'd100, 25'h0000000, 1'b0, 32'h00000000, 3'b010};
        vecs[10] = '{1'b0, 8'd0,   25'h0000000, 1'b1, 32'h00000000, 3'b011};
        vecs[11] = '{1'b0, 8'd0,   25'h0000000, 1'b0, 32'h00000000, 3'b010};

        test_reset();
        test_exact();
        test_rounding();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_round_pack.md
FPU_ROUND_PACK -- requirements
Module: fpu_round_pack

Interface
REQ-001 SHALL declare parameter LATENCY, default 2, pipeline depth in register stages; only the value 2 is legal.
REQ-002 SHALL declare ports in this order:
- clk_i, input, 1 bit: the single clock.
- rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL declare:
- valid_i, input, 1 bit: upstream operand valid.
- ready_o, output, 1 bit: stage can accept an operand.
REQ-004 SHALL declare:
- sign_i, input, 1 bit: result sign.
- exp_i, input, 8 bits: biased exponent from the normaliser.
REQ-005 SHALL declare mant_i, input, 25 bits: normalised mantissa, with bit24 the hidden one, bits23:1 the fraction and bit0 the guard bit.
REQ-006 SHALL declare sticky_i, input, 1 bit: OR of all bits shifted out below the guard bit.
REQ-007 SHALL declare:
- valid_o, output, 1 bit: result valid.
- ready_i, input, 1 bit: downstream accepts the result.
REQ-008 SHALL declare:
- result_o, output, 32 bits: packed IEEE-754 single-precision value.
- flags_o, output, 3 bits: {overflow, underflow, inexact}.

Function
REQ-009 A transfer SHALL occur on a rising clock edge when valid and ready are both high, on either port.
REQ-010 Latency SHALL be exactly 2 cycles from input transfer to valid_o, absent backpressure.
REQ-011 Throughput SHALL be one operand per cycle while ready_i=1.
REQ-012 Stage 1 SHALL register three things:
- the round-increment decision;
- the 25-bit sum {1'b0, mant_i[24:1]} + incr;
- sign, exponent and inexact (guard|sticky).
REQ-013 Round-to-nearest-even SHALL set incr = guard & (sticky | mant_i[1]).
REQ-014 If the stage-2 sum overflows to bit24, the exponent SHALL be incremented and the fraction SHALL be sum[23:1] shifted right by one, i.e. all zeros.
REQ-015 An exponent of 255, either at input or after the rounding increment, SHALL produce ±infinity (frac=0) with overflow=1 and inexact=1.
REQ-016 exp_i==0 or mant_i[24]==0 SHALL produce ±zero with underflow=1 and inexact equal to (mant_i!=0 | sticky_i); denormals are flushed to zero.
REQ-017 result_o SHALL equal {sign, exp, frac[22:0]}; flags_o SHALL be registered alongside result_o.
REQ-018 Each stage SHALL hold its contents while its downstream neighbour is full and not ready; no operand SHALL be dropped or duplicated.
REQ-019 ready_o SHALL equal !stage1_valid | stage2_accepts, where stage2_accepts = !valid_o | ready_i; there is no combinational path from valid_i to ready_o.
REQ-020 When input accept and output retire occur in the same cycle, both SHALL occur, and the pipeline SHALL advance.
REQ-021 result_o and flags_o SHALL remain stable while valid_o=1 and ready_i=0.

Reset
REQ-022 Asserting rst_ni low SHALL immediately clear both stage valid bits, valid_o, result_o (to 0) and flags_o (to 0).
REQ-023 ready_o SHALL be 1 during and after reset.
REQ-024 Operands in flight when reset asserts mid-operation SHALL be discarded.
REQ-025 Data registers other than the outputs need no reset.

Configuration
REQ-026 With macro FPU_ROUND_MODES_EN defined, the block SHALL add input rm_i (3 bits), sampled with valid_i.
REQ-027 With FPU_ROUND_MODES_EN defined, incr SHALL follow the decoded rounding mode:
- RNE: as REQ-013.
- RTZ: 0.
- RDN: sign & (guard|sticky).
- RUP: !sign & (guard|sticky).
- Other codes: treated as RNE.
REQ-028 With FPU_ROUND_MODES_EN defined, overflow under RTZ, under RDN with a positive sign, or under RUP with a negative sign SHALL saturate to max finite (exp=254, frac all ones) rather than infinity.
REQ-029 Without FPU_ROUND_MODES_EN, rm_i SHALL be absent and the block SHALL be RNE only.

Structure
REQ-030 Shared package fpu_pkg SHALL hold:
- the round-mode enum round_mode_e (RNE=0, RTZ=1, RDN=2, RUP=3);
- constants EXP_MAX=8'd255, EXP_MAXF=8'd254, FRAC_W=23;
- the flag bit indices.
REQ-031 The combinational increment decision SHALL be one sub-module, fpu_round_incr, with inputs sign, lsb, guard, sticky and rm, and output incr; it is instantiated in stage 1.

Verification
REQ-032 Exact value: sign=0, exp=127, mant=25'h1000000, sticky=0 -> result 32'h3F800000 (1.0), flags 000, valid_o two cycles after the transfer.
REQ-033 Tie rounding to even: mant=25'h1FFFFFF, exp=127, sticky=0 -> mantissa carry, result 32'h40000000, flags 001.
REQ-034 Overflow: exp=254, mant=25'h1FFFFFF -> 32'h7F800000, flags 101; under FPU_ROUND_MODES_EN with rm=RTZ -> 32'h7F7FFFFF, flags 101.
REQ-035 Underflow: exp=0, mant=25'h0000001, sign=1 -> 32'h80000000, flags 011.
REQ-036 Backpressure: stream 4 back-to-back operands with ready_i held low for 3 cycles mid-stream:
- ready_o falls once both stages are full;
- all 4 results emerge in order, with none lost or repeated.
REQ-037 Reset mid-stream: assert rst_ni with both stages full -> valid_o=0, result_o=0 and ready_o=1 immediately; no stale result appears after release.
